// File: rtl/gpu_column_sequencer.sv
// Column scan controller: walks one ray's column top to bottom through the wall lookup
// and streams registered pixels downstream. Optional perf counters under GPU_SEQ_PERF_EN.
module gpu_column_sequencer #(
    parameter  int SCREEN_WIDTH     = 320,
    parameter  int SCREEN_HEIGHT_PX = 240,
    parameter  int TEXTURE_SIZE     = 64,
    localparam int UVW              = $clog2(TEXTURE_SIZE)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           col_valid,
    output logic           col_ready,
    input  logic [15:0]    col_distance,
    input  logic [UVW-1:0] col_uv_x,
    output logic [15:0]    lk_distance,
    output logic [9:0]     lk_screen_y,
    input  logic [UVW-1:0] lk_uv_y,
    input  logic           lk_inside,
    input  logic           lk_above,
    output logic           px_valid,
    input  logic           px_ready,
    output logic [9:0]     px_x,
    output logic [9:0]     px_y,
    output logic [1:0]     px_kind,
    output logic [UVW-1:0] px_uv_x,
    output logic [UVW-1:0] px_uv_y,
    output logic           px_eoc,
    output logic           px_eof,
    output logic           busy
`ifdef GPU_SEQ_PERF_EN
   ,output logic [31:0]    stall_count,
    output logic [31:0]    frame_cycles
`endif
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t         state, state_nxt;
    logic           armed;
    logic [9:0]     x, y;
    logic [UVW-1:0] uv_x;
    logic           slot_free, accept, capture, retire, last_row, last_col;
    logic [1:0]     kind;

    assign slot_free   = !px_valid || px_ready;
    assign last_row    = (y == 10'(SCREEN_HEIGHT_PX - 1));
    assign last_col    = (x == 10'(SCREEN_WIDTH - 1));
    assign kind        = lk_above ? 2'd0 : (lk_inside ? 2'd1 : 2'd2);
    assign lk_screen_y = y;
    assign busy        = (state != IDLE);

    always_comb begin
        state_nxt = state;
        col_ready = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        retire    = 1'b0;
        case (state)
            IDLE: begin
                // armed keeps ready low until the first clock after reset release
                col_ready = armed;
                if (armed && col_valid) begin
                    accept    = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: if (slot_free) begin
                capture = 1'b1;
                if (last_row) state_nxt = DRAIN;
            end
            DRAIN: if (slot_free) begin
                retire    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            armed       <= 1'b0;
            x           <= '0;
            y           <= '0;
            uv_x        <= '0;
            lk_distance <= 16'h0100;
            px_valid    <= 1'b0;
            px_x        <= '0;
            px_y        <= '0;
            px_kind     <= '0;
            px_uv_x     <= '0;
            px_uv_y     <= '0;
            px_eoc      <= 1'b0;
            px_eof      <= 1'b0;
        end else begin
            state <= state_nxt;
            armed <= 1'b1;
            if (accept) begin
                // zero distance would divide by zero inside the lookup
                lk_distance <= (col_distance == 16'h0000) ? 16'h0001 : col_distance;
                uv_x        <= col_uv_x;
                y           <= '0;
            end
            if (capture) begin
                px_valid <= 1'b1;
                px_x     <= x;
                px_y     <= y;
                px_kind  <= kind;
                px_uv_x  <= (kind == 2'd1) ? uv_x : '0;
                px_uv_y  <= (kind == 2'd1) ? lk_uv_y : '0;
                px_eoc   <= last_row;
                px_eof   <= last_row && last_col;
                y        <= y + 10'd1;
            end
            if (retire) begin
                px_valid <= 1'b0;
                px_eoc   <= 1'b0;
                px_eof   <= 1'b0;
                x        <= last_col ? '0 : x + 10'd1;
            end
        end
    end

`ifdef GPU_SEQ_PERF_EN
    logic frame_run;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_run    <= 1'b0;
            stall_count  <= '0;
            frame_cycles <= '0;
        end else if (accept && x == '0) begin
            frame_run    <= 1'b1;
            stall_count  <= '0;
            frame_cycles <= 32'd1;
        end else if (frame_run) begin
            frame_cycles <= frame_cycles + 32'd1;
            if (px_valid && !px_ready) stall_count <= stall_count + 32'd1;
            if (px_valid && px_ready && px_eof) frame_run <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_gpu_column_sequencer.sv
// Randomized bench for gpu_column_sequencer with an attached behavioural wall lookup
// and a per-pixel reference model.
module tb_gpu_column_sequencer;
    localparam int W = 320;
    localparam int H = 240;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [1:0] kind;
        logic [5:0] uvx;
        logic [5:0] uvy;
        logic       eoc;
        logic       eof;
    } pix_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        col_valid = 1'b0;
    logic        col_ready;
    logic [15:0] col_distance = '0;
    logic [5:0]  col_uv_x = '0;
    logic [15:0] lk_distance;
    logic [9:0]  lk_screen_y;
    logic [5:0]  lk_uv_y;
    logic        lk_inside, lk_above;
    logic        px_valid;
    logic        px_ready = 1'b1;
    logic [9:0]  px_x, px_y;
    logic [1:0]  px_kind;
    logic [5:0]  px_uv_x, px_uv_y;
    logic        px_eoc, px_eof, busy;

    int   checks = 0;
    int   errors = 0;
    pix_t q[$];
    int   unstable;
    int   first_cyc;
    int   exp_x;

    gpu_column_sequencer dut (
        .clk(clk), .reset(reset), .col_valid(col_valid), .col_ready(col_ready),
        .col_distance(col_distance), .col_uv_x(col_uv_x), .lk_distance(lk_distance),
        .lk_screen_y(lk_screen_y), .lk_uv_y(lk_uv_y), .lk_inside(lk_inside),
        .lk_above(lk_above), .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x),
        .px_y(px_y), .px_kind(px_kind), .px_uv_x(px_uv_x), .px_uv_y(px_uv_y),
        .px_eoc(px_eoc), .px_eof(px_eof), .busy(busy)
    );

    always #5 clk = ~clk;

    // Wall spans 61440/d rows (capped at the screen), centred vertically.
    function automatic logic [7:0] lookup(input logic [15:0] d, input logic [9:0] yy);
        int h, top, yi;
        h = 61440 / ((d == 16'h0) ? 1 : int'(d));
        if (h > H) h = H;
        if (h < 1) h = 1;
        top = (H - h) / 2;
        yi  = int'(yy);
        if (yi < top) return {1'b1, 1'b0, 6'd0};
        if (yi < top + h) return {1'b0, 1'b1, 6'((yi - top) * 64 / h)};
        return 8'd0;
    endfunction

    assign {lk_above, lk_inside, lk_uv_y} = lookup(lk_distance, lk_screen_y);

    function automatic pix_t exp_pix(input int xx, input int yy, input logic [15:0] d,
                                     input logic [5:0] u);
        pix_t p;
        logic [7:0] r;
        r      = lookup((d == 16'h0) ? 16'h1 : d, 10'(yy));
        p.x    = 10'(xx);
        p.y    = 10'(yy);
        p.kind = r[7] ? 2'd0 : (r[6] ? 2'd1 : 2'd2);
        p.uvx  = (p.kind == 2'd1) ? u : 6'd0;
        p.uvy  = (p.kind == 2'd1) ? r[5:0] : 6'd0;
        p.eoc  = (yy == H - 1);
        p.eof  = p.eoc && (xx == W - 1);
        return p;
    endfunction

    // Presents one column and records every transfer into q. abort_y >= 0 returns at the
    // negedge where that row is first valid, leaving the column unfinished.
    task automatic send_column(input logic [15:0] d, input logic [5:0] u, input int stall_pct,
                               input int abort_y, output int cyc);
        pix_t cur, prev;
        logic prev_stall, done;
        int   guard;
        q.delete();
        unstable = 0; first_cyc = -1; cyc = 0; done = 1'b0; prev_stall = 1'b0; prev = '0;
        guard = 0;
        while (!col_ready && guard < 1000) begin
            @(posedge clk); #1; guard++;
        end
        if (!col_ready) begin
            errors++;
            $display("FAIL col_ready_timeout: col_ready=%0b want 1", col_ready);
            return;
        end
        col_valid = 1'b1; col_distance = d; col_uv_x = u;
        @(posedge clk); #1;
        col_valid = 1'b0;
        cyc = 1;
        while (!done && cyc < 5000) begin
            px_ready = ($urandom_range(99) >= stall_pct);
            @(negedge clk);
            if (px_valid) begin
                cur = {px_x, px_y, px_kind, px_uv_x, px_uv_y, px_eoc, px_eof};
                if (first_cyc < 0) first_cyc = cyc;
                if (abort_y >= 0 && int'(px_y) == abort_y) return;
                if (prev_stall && cur !== prev) unstable++;
                if (px_ready) begin
                    q.push_back(cur);
                    if (px_eoc) done = 1'b1;
                end
                prev_stall = !px_ready;
                prev = cur;
            end else prev_stall = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        px_ready = 1'b1;
        if (!done) begin
            errors++;
            $display("FAIL column_timeout: transfers=%0d want %0d", q.size(), H);
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({col_ready, px_valid, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: ready/valid/busy=%b want 000", {col_ready, px_valid, busy});
        end
        checks++;
        if (lk_distance !== 16'h0100) begin
            errors++;
            $display("FAIL reset_distance: got %h want 0100", lk_distance);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({col_ready, px_valid, busy} !== 3'b100) begin
            errors++;
            $display("FAIL release_flags: ready/valid/busy=%b want 100", {col_ready, px_valid, busy});
        end
        exp_x = 0;
    endtask

    task automatic test_column();
        int cyc;
        pix_t e;
        send_column(16'h0200, 6'd17, 0, -1, cyc);
        checks++;
        if (q.size() != H) begin
            errors++;
            $display("FAIL col_count: got %0d want %0d", q.size(), H);
        end
        checks++;
        if (cyc != H + 2) begin
            errors++;
            $display("FAIL col_period: got %0d want %0d", cyc, H + 2);
        end
        checks++;
        if (first_cyc != 2) begin
            errors++;
            $display("FAIL col_latency: got %0d want 2", first_cyc);
        end
        if (q.size() == H) begin
            checks++;
            if ({q[30].kind, q[30].uvx, q[30].uvy} !== 14'd0) begin
                errors++;
                $display("FAIL ceiling_y30: kind/uv=%h want 0", {q[30].kind, q[30].uvx, q[30].uvy});
            end
            checks++;
            if (q[120].kind !== 2'd1 || q[120].uvx !== 6'd17) begin
                errors++;
                $display("FAIL wall_y120: kind=%0d uvx=%0d want 1/17", q[120].kind, q[120].uvx);
            end
            checks++;
            if (q[200].kind !== 2'd2) begin
                errors++;
                $display("FAIL floor_y200: kind=%0d want 2", q[200].kind);
            end
        end
        foreach (q[i]) begin
            e = exp_pix(exp_x, i, 16'h0200, 6'd17);
            checks++;
            if (q[i] !== e) begin
                errors++;
                $display("FAIL col_pixel[%0d]: got %h want %h", i, q[i], e);
            end
        end
        exp_x = (exp_x + 1) % W;
    endtask

    task automatic test_zero_distance();
        int cyc;
        pix_t e;
        logic [5:0] u;
        u = 6'($urandom);
        send_column(16'h0000, u, 0, -1, cyc);
        checks++;
        if (lk_distance !== 16'h0001) begin
            errors++;
            $display("FAIL zero_clamp: got %h want 0001", lk_distance);
        end
        checks++;
        if (q.size() != H) begin
            errors++;
            $display("FAIL zero_count: got %0d want %0d", q.size(), H);
        end
        foreach (q[i]) begin
            e = exp_pix(exp_x, i, 16'h0000, u);
            checks++;
            if (q[i] !== e) begin
                errors++;
                $display("FAIL zero_pixel[%0d]: got %h want %h", i, q[i], e);
            end
        end
        exp_x = (exp_x + 1) % W;
    endtask

    task automatic test_stall();
        int cyc;
        pix_t e;
        logic [15:0] d;
        logic [5:0] u;
        d = 16'($urandom_range(16'h0080, 16'h0800));
        u = 6'($urandom);
        send_column(d, u, 50, -1, cyc);
        checks++;
        if (unstable != 0) begin
            errors++;
            $display("FAIL stall_stable: changes=%0d want 0", unstable);
        end
        checks++;
        if (q.size() != H) begin
            errors++;
            $display("FAIL stall_count: got %0d want %0d", q.size(), H);
        end
        foreach (q[i]) begin
            e = exp_pix(exp_x, i, d, u);
            checks++;
            if (q[i] !== e) begin
                errors++;
                $display("FAIL stall_pixel[%0d]: got %h want %h", i, q[i], e);
            end
        end
        exp_x = (exp_x + 1) % W;
    endtask

    task automatic test_reset_mid();
        int cyc;
        pix_t e;
        logic [15:0] d;
        d = 16'($urandom_range(16'h0100, 16'h0400));
        send_column(d, 6'd9, 0, 100, cyc);
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({col_ready, px_valid, busy, px_eoc} !== 4'b0000 || px_y !== 10'd0 || px_x !== 10'd0) begin
            errors++;
            $display("FAIL midreset_clear: rdy/vld/busy/eoc=%b x=%0d y=%0d want 0",
                     {col_ready, px_valid, busy, px_eoc}, px_x, px_y);
        end
        checks++;
        if (lk_distance !== 16'h0100) begin
            errors++;
            $display("FAIL midreset_distance: got %h want 0100", lk_distance);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        exp_x = 0;
        send_column(d, 6'd9, 0, -1, cyc);
        checks++;
        if (q.size() != H) begin
            errors++;
            $display("FAIL midreset_count: got %0d want %0d", q.size(), H);
        end
        foreach (q[i]) begin
            e = exp_pix(0, i, d, 6'd9);
            checks++;
            if (q[i] !== e) begin
                errors++;
                $display("FAIL midreset_pixel[%0d]: got %h want %h", i, q[i], e);
            end
        end
        exp_x = 1;
    endtask

    task automatic test_back_to_back();
        int cyc, eofs;
        pix_t e;
        logic [15:0] d;
        logic [5:0] u;
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        exp_x = 0;
        eofs = 0;
        for (int c = 0; c <= W; c++) begin
            d = 16'($urandom_range(16'h0040, 16'h0C00));
            u = 6'($urandom);
            send_column(d, u, 0, -1, cyc);
            checks++;
            if (cyc != H + 2 || q.size() != H) begin
                errors++;
                $display("FAIL b2b_col%0d: period=%0d count=%0d want %0d/%0d", c, cyc, q.size(), H + 2, H);
            end
            foreach (q[i]) begin
                e = exp_pix(exp_x, i, d, u);
                if (q[i].eof === 1'b1) eofs++;
                checks++;
                if (q[i] !== e) begin
                    errors++;
                    $display("FAIL b2b_pixel c%0d y%0d: got %h want %h", c, i, q[i], e);
                end
            end
            if (c == W && q.size() > 0) begin
                checks++;
                if (q[0].x !== 10'd0) begin
                    errors++;
                    $display("FAIL x_wrap: got %0d want 0", q[0].x);
                end
            end
            exp_x = (exp_x + 1) % W;
        end
        checks++;
        if (eofs != 1) begin
            errors++;
            $display("FAIL eof_total: got %0d want 1", eofs);
        end
    endtask

    initial begin
        test_reset();
        test_column();
        test_zero_distance();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
